// File: rtl/spart_pkg.sv
// Shared types and constants for the buffered SPART.
// SPART_PARITY_EN adds the even-parity state to both serial FSMs.
package spart_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'b00,
    ADDR_STATUS = 2'b01,
    ADDR_DBL    = 2'b10,
    ADDR_DBH    = 2'b11
  } ioaddr_e;

  localparam int unsigned ST_RDA  = 0;
  localparam int unsigned ST_TBR  = 1;
  localparam int unsigned ST_OVR  = 2;
  localparam int unsigned ST_FE   = 3;
  localparam int unsigned ST_TXOF = 4;
  localparam int unsigned ST_PE   = 5;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef SPART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef SPART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/spart_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push and pop may coincide even when full or empty.
module spart_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO is still accepted.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spart_buffered.sv
// Buffered SPART: CPU register bus, baud generator, 8N1 TX/RX engines with FIFOs.
// Define SPART_PARITY_EN to insert/check an even-parity bit after D7.
module spart_buffered
  import spart_pkg::*;
#(
  parameter int unsigned TX_DEPTH   = 8,
  parameter int unsigned RX_DEPTH   = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter logic [15:0] DIV_RESET  = 16'd324
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  localparam int unsigned OCW = $clog2(OVERSAMPLE);

  ioaddr_e    addr;
  logic       bus_wr, bus_rd, st_rd, db_wr;
  logic [7:0] rd_data, status;
  logic [15:0] db_q, db_d, cnt_q;
  logic       tick;

  logic       tx_full, tx_empty, tx_push_req, tx_pop, txof_ev;
  logic [7:0] tx_dout;
  logic       rx_full, rx_empty, rx_pop, rx_push, rx_stop_smp, ovr_ev, fe_ev;
  logic [7:0] rx_dout;
  logic       ovr_q, fe_q, txof_q, pe_bit;

  tx_state_t      tx_state;
  logic [OCW-1:0] tx_ocnt;
  logic [2:0]     tx_bit;
  logic [7:0]     tx_sh;
  logic           tx_last;

  rx_state_t      rx_state;
  logic [OCW-1:0] rx_ocnt;
  logic [2:0]     rx_bit;
  logic [7:0]     rx_sh;
  logic [1:0]     rx_sync;
  logic           rx_s, rx_prev, rx_last, rx_half;

  assign addr   = ioaddr_e'(ioaddr);
  assign bus_wr = iocs && !iorw;
  assign bus_rd = iocs && iorw;
  assign st_rd  = bus_rd && (addr == ADDR_STATUS);
  assign db_wr  = bus_wr && ((addr == ADDR_DBL) || (addr == ADDR_DBH));

  assign rda = !rx_empty;
  assign tbr = !tx_full;
  assign status = {2'b00, pe_bit, txof_q, fe_q, ovr_q, tbr, rda};

  always_comb begin
    rd_data = 8'h00;
    unique case (addr)
      ADDR_DATA:   rd_data = rx_empty ? 8'h00 : rx_dout;
      ADDR_STATUS: rd_data = status;
      ADDR_DBL:    rd_data = db_q[7:0];
      ADDR_DBH:    rd_data = db_q[15:8];
    endcase
  end

  assign databus = bus_rd ? rd_data : 8'hzz;

  always_comb begin
    db_d = db_q;
    if (bus_wr && addr == ADDR_DBL) db_d[7:0]  = databus;
    if (bus_wr && addr == ADDR_DBH) db_d[15:8] = databus;
  end

  // Counter ticks on 0, so the tick period is DB+1 clocks.
  assign tick = (cnt_q == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q  <= DIV_RESET;
      cnt_q <= DIV_RESET;
    end else begin
      db_q <= db_d;
      if (db_wr)      cnt_q <= db_d;
      else if (tick)  cnt_q <= db_q;
      else            cnt_q <= cnt_q - 16'd1;
    end
  end

  // TX path
  assign tx_push_req = bus_wr && (addr == ADDR_DATA);
  assign tx_last     = (tx_ocnt == OCW'(OVERSAMPLE - 1));
  assign tx_pop      = tick && !tx_empty &&
                       ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_last));
  assign txof_ev     = tx_push_req && tx_full && !tx_pop;

  spart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push_req),
    .pop   (tx_pop),
    .din   (databus),
    .full  (tx_full),
    .empty (tx_empty),
    .dout  (tx_dout)
  );

`ifdef SPART_PARITY_EN
  logic tx_par;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_ocnt  <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      txd      <= 1'b1;
`ifdef SPART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tick) begin
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_sh    <= tx_dout;
            txd      <= 1'b0;
            tx_ocnt  <= '0;
            tx_state <= TX_START;
`ifdef SPART_PARITY_EN
            tx_par   <= ^tx_dout;
`endif
          end
        end
        TX_START: begin
          if (tx_last) begin
            tx_ocnt  <= '0;
            txd      <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end else tx_ocnt <= tx_ocnt + OCW'(1);
        end
        TX_DATA: begin
          if (tx_last) begin
            tx_ocnt <= '0;
            if (tx_bit == 3'd7) begin
`ifdef SPART_PARITY_EN
              txd      <= tx_par;
              tx_state <= TX_PARITY;
`else
              txd      <= 1'b1;
              tx_state <= TX_STOP;
`endif
            end else begin
              tx_bit <= tx_bit + 3'd1;
              txd    <= tx_sh[0];
              tx_sh  <= tx_sh >> 1;
            end
          end else tx_ocnt <= tx_ocnt + OCW'(1);
        end
`ifdef SPART_PARITY_EN
        TX_PARITY: begin
          if (tx_last) begin
            tx_ocnt  <= '0;
            txd      <= 1'b1;
            tx_state <= TX_STOP;
          end else tx_ocnt <= tx_ocnt + OCW'(1);
        end
`endif
        TX_STOP: begin
          if (tx_last) begin
            tx_ocnt <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (!tx_empty) begin
              tx_sh    <= tx_dout;
              txd      <= 1'b0;
              tx_state <= TX_START;
`ifdef SPART_PARITY_EN
              tx_par   <= ^tx_dout;
`endif
            end else tx_state <= TX_IDLE;
          end else tx_ocnt <= tx_ocnt + OCW'(1);
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX path
  assign rx_s        = rx_sync[1];
  assign rx_last     = (rx_ocnt == OCW'(OVERSAMPLE - 1));
  assign rx_half     = (rx_ocnt == OCW'(OVERSAMPLE / 2 - 1));
  assign rx_pop      = bus_rd && (addr == ADDR_DATA) && !rx_empty;
  assign rx_stop_smp = (rx_state == RX_STOP) && tick && rx_last;
  assign rx_push     = rx_stop_smp && (!rx_full || rx_pop);
  assign ovr_ev      = rx_stop_smp && rx_full && !rx_pop;
  assign fe_ev       = rx_push && !rx_s;

  spart_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_sh),
    .full  (rx_full),
    .empty (rx_empty),
    .dout  (rx_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_ocnt  <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_sync <= {rx_sync[0], rxd};
      rx_prev <= rx_s;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_ocnt  <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_half) begin
              rx_ocnt  <= '0;
              rx_bit   <= '0;
              rx_state <= rx_s ? RX_IDLE : RX_DATA;
            end else rx_ocnt <= rx_ocnt + OCW'(1);
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (rx_last) begin
              rx_ocnt <= '0;
              rx_sh   <= {rx_s, rx_sh[7:1]};
              if (rx_bit == 3'd7) begin
`ifdef SPART_PARITY_EN
                rx_state <= RX_PARITY;
`else
                rx_state <= RX_STOP;
`endif
              end else rx_bit <= rx_bit + 3'd1;
            end else rx_ocnt <= rx_ocnt + OCW'(1);
          end
        end
`ifdef SPART_PARITY_EN
        RX_PARITY: begin
          if (tick) begin
            if (rx_last) begin
              rx_ocnt  <= '0;
              rx_state <= RX_STOP;
            end else rx_ocnt <= rx_ocnt + OCW'(1);
          end
        end
`endif
        RX_STOP: begin
          if (tick) begin
            if (rx_last) begin
              rx_ocnt  <= '0;
              rx_state <= RX_IDLE;
            end else rx_ocnt <= rx_ocnt + OCW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Sticky status: a same-cycle event beats the clear from a status read.
`ifdef SPART_PARITY_EN
  logic pe_q, pe_ev;
  assign pe_ev  = (rx_state == RX_PARITY) && tick && rx_last && (rx_s != ^rx_sh);
  assign pe_bit = pe_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pe_q <= 1'b0;
    else     pe_q <= pe_ev | (pe_q & ~st_rd);
  end
`else
  assign pe_bit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q  <= 1'b0;
      fe_q   <= 1'b0;
      txof_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_ev  | (ovr_q  & ~st_rd);
      fe_q   <= fe_ev   | (fe_q   & ~st_rd);
      txof_q <= txof_ev | (txof_q & ~st_rd);
    end
  end

endmodule
